// File: rtl/dfe_pkg.sv
// Shared types and helpers for the DFE filter array.
// Also provides the round/saturate step used at the CIC decimator output.
package dfe_pkg;

   localparam int CIC_DATA_WIDTH   = 16;
   localparam int CIC_DATA_FRAC    = 15;
   localparam int CIC_NUM_STAGES   = 5;
   localparam int CIC_MAX_DEC_LOG2 = 4;
   localparam int CIC_SEL_WIDTH    = 3;
   localparam int CIC_ACC_WIDTH    = CIC_DATA_WIDTH + CIC_NUM_STAGES * CIC_MAX_DEC_LOG2;
   localparam int CIC_SHIFT_WIDTH  = 8;

   typedef logic signed [CIC_DATA_WIDTH-1:0] sample_t;
   typedef logic signed [CIC_ACC_WIDTH-1:0]  cic_acc_t;
   typedef logic [CIC_SHIFT_WIDTH-1:0]       cic_shift_t;

   typedef struct packed {
      sample_t data;
      logic    overflow;
      logic    underflow;
   } sat_result_t;

   // One guard bit keeps the half-up rounding term from wrapping near full scale.
   function automatic sat_result_t sat_round(input cic_acc_t acc, input cic_shift_t shift);
      logic signed [CIC_ACC_WIDTH:0]               ext;
      logic signed [CIC_ACC_WIDTH:0]               rnd;
      logic signed [CIC_ACC_WIDTH:0]               shifted;
      logic [CIC_ACC_WIDTH-CIC_DATA_WIDTH+1:0]     upper;
      sat_result_t                                 res;
      ext = {acc[CIC_ACC_WIDTH-1], acc};
      rnd = '0;
      if (shift != '0) begin
         rnd = {{CIC_ACC_WIDTH{1'b0}}, 1'b1} << (shift - 1'b1);
      end
      shifted       = (ext + rnd) >>> shift;
      upper         = shifted[CIC_ACC_WIDTH:CIC_DATA_WIDTH-1];
      res.data      = shifted[CIC_DATA_WIDTH-1:0];
      res.overflow  = 1'b0;
      res.underflow = 1'b0;
      if (!((&upper) | ~(|upper))) begin
         if (shifted[CIC_ACC_WIDTH]) begin
            res.underflow = 1'b1;
            res.data      = {1'b1, {(CIC_DATA_WIDTH-1){1'b0}}};
         end else begin
            res.overflow  = 1'b1;
            res.data      = {1'b0, {(CIC_DATA_WIDTH-1){1'b1}}};
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/cic_decimator_if.sv
// Sample stream, configuration and status bundle of the CIC decimator.
interface cic_decimator_if
   import dfe_pkg::*;
#(
   parameter int DATA_WIDTH = CIC_DATA_WIDTH,
   parameter int SEL_WIDTH  = CIC_SEL_WIDTH
);

   logic                         valid_in;
   logic signed [DATA_WIDTH-1:0] cic_in;
   logic                         bypass;
   logic                         cfg_wr_en;
   logic [SEL_WIDTH-1:0]         dec_sel;
   logic [SEL_WIDTH-1:0]         dec_sel_out;
   logic signed [DATA_WIDTH-1:0] cic_out;
   logic                         valid_out;
   logic                         overflow;
   logic                         underflow;

   modport master (
      output valid_in, cic_in, bypass, cfg_wr_en, dec_sel,
      input  dec_sel_out, cic_out, valid_out, overflow, underflow
   );

   modport slave (
      input  valid_in, cic_in, bypass, cfg_wr_en, dec_sel,
      output dec_sel_out, cic_out, valid_out, overflow, underflow
   );

endinterface

// File: rtl/cic_comb_chain.sv
// Comb section of the CIC decimator: N differentiators (M = 1) run at the decimated rate.
module cic_comb_chain
   import dfe_pkg::*;
#(
   parameter int ACC_WIDTH  = CIC_ACC_WIDTH,
   parameter int NUM_STAGES = CIC_NUM_STAGES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        enable,
   input  logic signed [ACC_WIDTH-1:0] din,
   output logic signed [ACC_WIDTH-1:0] dout
);

   logic signed [ACC_WIDTH-1:0] c    [NUM_STAGES+1];
   logic signed [ACC_WIDTH-1:0] dly_q[NUM_STAGES];
   logic signed [ACC_WIDTH-1:0] dly_d[NUM_STAGES];

   always_comb begin
      c[0] = din;
      for (int k = 0; k < NUM_STAGES; k++) begin
         c[k+1] = c[k] - dly_q[k];
      end
   end

   // Each delay captures its own stage input, so the chain is a pure difference per stage.
   always_comb begin
      dly_d = dly_q;
      if (clear) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            dly_d[k] = '0;
         end
      end else if (enable) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            dly_d[k] = c[k];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            dly_q[k] <= '0;
         end
      end else begin
         dly_q <= dly_d;
      end
   end

   assign dout = c[NUM_STAGES];

endmodule

// File: rtl/cic_decimator.sv
// Programmable-ratio CIC decimator (R = 2^dec_sel) with exact gain normalisation,
// rounding/saturation to the sample width and a registered bypass path.
module cic_decimator
   import dfe_pkg::*;
#(
   parameter int DATA_WIDTH   = CIC_DATA_WIDTH,
   parameter int NUM_STAGES   = CIC_NUM_STAGES,
   parameter int MAX_DEC_LOG2 = CIC_MAX_DEC_LOG2,
   parameter int SEL_WIDTH    = CIC_SEL_WIDTH
) (
   input logic            clk,
   input logic            rst,
   cic_decimator_if.slave bus
);

   localparam int ACC_WIDTH = DATA_WIDTH + NUM_STAGES * MAX_DEC_LOG2;
   localparam int PH_WIDTH  = (MAX_DEC_LOG2 > 0) ? MAX_DEC_LOG2 : 1;

   typedef logic signed [ACC_WIDTH-1:0] acc_t;

   logic [SEL_WIDTH-1:0] ratio_q;
   logic [SEL_WIDTH-1:0] ratio_d;
   logic [PH_WIDTH-1:0]  phase_q;
   logic [PH_WIDTH-1:0]  phase_d;
   logic [PH_WIDTH-1:0]  phase_last;
   logic                 dec_strobe_q;
   logic                 dec_strobe_d;
   acc_t                 int_q[NUM_STAGES];
   acc_t                 int_d[NUM_STAGES];
   acc_t                 in_ext;
   acc_t                 comb_out;
   logic                 clear;
   cic_shift_t           shift_amt;
   sat_result_t          sat_res;
   sample_t              cic_out_q;
   sample_t              cic_out_d;
   logic                 valid_out_q;
   logic                 valid_out_d;
   logic                 overflow_q;
   logic                 overflow_d;
   logic                 underflow_q;
   logic                 underflow_d;

   // Bypass and reconfiguration both hold the filter state at zero.
   assign clear  = bus.bypass | bus.cfg_wr_en;
   assign in_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.cic_in[DATA_WIDTH-1]}}, bus.cic_in};

   always_comb begin
      ratio_d = ratio_q;
      if (bus.cfg_wr_en) begin
         if (bus.dec_sel > SEL_WIDTH'(MAX_DEC_LOG2)) begin
            ratio_d = SEL_WIDTH'(MAX_DEC_LOG2);
         end else begin
            ratio_d = bus.dec_sel;
         end
      end
   end

   // Pipelined integrators: each stage adds last cycle's value of its predecessor.
   always_comb begin
      int_d = int_q;
      if (clear) begin
         for (int k = 0; k < NUM_STAGES; k++) begin
            int_d[k] = '0;
         end
      end else if (bus.valid_in) begin
         int_d[0] = int_q[0] + in_ext;
         for (int k = 1; k < NUM_STAGES; k++) begin
            int_d[k] = int_q[k] + int_q[k-1];
         end
      end
   end

   assign phase_last = PH_WIDTH'((32'd1 << ratio_q) - 32'd1);

   always_comb begin
      phase_d      = phase_q;
      dec_strobe_d = 1'b0;
      if (clear) begin
         phase_d = '0;
      end else if (bus.valid_in) begin
         if (phase_q == phase_last) begin
            phase_d      = '0;
            dec_strobe_d = 1'b1;
         end else begin
            phase_d = phase_q + 1'b1;
         end
      end
   end

   cic_comb_chain #(
      .ACC_WIDTH  (ACC_WIDTH),
      .NUM_STAGES (NUM_STAGES)
   ) u_comb (
      .clk    (clk),
      .rst    (rst),
      .clear  (clear),
      .enable (dec_strobe_q),
      .din    (int_q[NUM_STAGES-1]),
      .dout   (comb_out)
   );

   // Gain is (2^ratio)^N, so a shift of N*ratio normalises it exactly.
   assign shift_amt = cic_shift_t'(NUM_STAGES) * cic_shift_t'(ratio_q);
   assign sat_res   = sat_round(comb_out, shift_amt);

   always_comb begin
      cic_out_d   = cic_out_q;
      valid_out_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      if (bus.bypass) begin
         cic_out_d   = bus.cic_in;
         valid_out_d = bus.valid_in;
      end else if (dec_strobe_q) begin
         cic_out_d   = sat_res.data;
         valid_out_d = 1'b1;
         overflow_d  = sat_res.overflow;
         underflow_d = sat_res.underflow;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ratio_q      <= SEL_WIDTH'(MAX_DEC_LOG2);
         phase_q      <= '0;
         dec_strobe_q <= 1'b0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            int_q[k] <= '0;
         end
         cic_out_q    <= '0;
         valid_out_q  <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         ratio_q      <= ratio_d;
         phase_q      <= phase_d;
         dec_strobe_q <= dec_strobe_d;
         int_q        <= int_d;
         cic_out_q    <= cic_out_d;
         valid_out_q  <= valid_out_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign bus.dec_sel_out = ratio_q;
   assign bus.cic_out     = cic_out_q;
   assign bus.valid_out   = valid_out_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;

endmodule
